bus_transfer_engine: RTL and testbench
======================================

BUS_TRANSFER_ENGINE -- requirements
Module: bus_transfer_engine

Interface
REQ-001 Parameter WIDTH, default 32, data/bus/address width in bits; legal range 8..64.
REQ-002 Parameter NREG, default 16, number of general registers; power of two, 2..32.
REQ-003 Parameter IW, default $clog2(NREG), register index width; derived, never overridden.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 clr  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid  in  1  command offered.
REQ-007 cmd_ready  out  1  engine can accept a command.
REQ-008 cmd_op  in  2  operation code: 00 MOV, 01 LDI, 10 LD, 11 ST.
REQ-009 cmd_rd, cmd_rs  in  IW each  destination index and source/address index.
REQ-010 cmd_imm  in  WIDTH  immediate value for LDI.
REQ-011 mem_req  out  1  memory request, held until acknowledged.
REQ-012 mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
REQ-013 mem_addr  out  WIDTH  MAR contents.
REQ-014 mem_wdata  out  WIDTH  MDR contents.
REQ-015 mem_rdata  in  WIDTH  read data; sampled only when mem_ack=1.
REQ-016 mem_ack  in  1  single-cycle completion from memory.
REQ-017 bus  out  WIDTH  current shared bus value; 0 when no source drives it.
REQ-018 done  out  1  one-cycle pulse when a command retires.
REQ-019 dbg_sel  in  IW / dbg_data  out  WIDTH  combinational register read port.

Function
REQ-020 The register file (NREG x WIDTH), MAR and MDR SHALL be loaded only from bus, except MDR on read ack, which SHALL load mem_rdata.
REQ-021 Exactly one source SHALL drive bus per cycle; bus SHALL be 0 in IDLE and MEM_WAIT.
REQ-022 FSM states SHALL be IDLE, XFER, MEM_ADDR, MEM_DATA, MEM_WAIT, MEM_WB.
REQ-023 cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid & cmd_ready, and its fields latched.
REQ-024 MOV/LDI: IDLE->XFER; in XFER bus = R[rs] (MOV) or imm (LDI), R[rd] written at end of cycle, done=1, ->IDLE.
REQ-025 LD: IDLE->MEM_ADDR (bus=R[rs], MAR load)->MEM_WAIT (mem_req=1, mem_we=0)->on mem_ack MDR<=mem_rdata ->MEM_WB (bus=MDR, R[rd] write, done=1)->IDLE.
REQ-026 ST: IDLE->MEM_ADDR (bus=R[rs], MAR load)->MEM_DATA (bus=R[rd], MDR load)->MEM_WAIT (mem_req=1, mem_we=1)->on mem_ack done=1, ->IDLE.
REQ-027 MEM_WAIT SHALL persist indefinitely while mem_ack=0, with mem_req, mem_we, mem_addr, mem_wdata stable.
REQ-028 mem_ack outside MEM_WAIT SHALL be ignored.
REQ-029 Latency accept->retire: MOV/LDI 1 cycle; LD 3+k; ST 3+k cycles, k = cycles waited for ack (k>=0 counting ack cycle as 1).
REQ-030 Source and destination equal (e.g. MOV R3,R3; LD R2,[R2]) SHALL be legal; written value is the bus value of that cycle.
REQ-031 dbg_data SHALL reflect R[dbg_sel] from the same cycle's register state (write visible the cycle after).

Reset
REQ-032 clr=1 at a rising edge SHALL force state IDLE, all registers, MAR, MDR to 0, mem_req=0, done=0; cmd_ready=1 on the cycle after.
REQ-033 clr during MEM_WAIT SHALL abandon the transaction; a coincident mem_ack SHALL be ignored and no register written.
REQ-034 clr SHALL take priority over any command acceptance or write in the same cycle.

Configuration
REQ-035 Macro BUS_TRANSFER_ENGINE_R0_ZERO_EN defined: R[0] SHALL always read 0 (bus, dbg_data, address) and writes to it SHALL be discarded, done still pulsing.
REQ-036 Macro undefined: R[0] SHALL be an ordinary register.

Verification
REQ-037 clr, LDI R5,0xDEADBEEF, MOV R7,R5 -> dbg R7=0xDEADBEEF; each done pulse 1 cycle after accept.
REQ-038 R1=0x100, R2=0xCAFE, ST [R1],R2, ack after 4 wait cycles -> mem_addr=0x100, mem_wdata=0xCAFE, mem_we=1 held stable until ack; done on ack cycle.
REQ-039 LD R3,[R1], mem_rdata=0x12345678 with immediate ack -> R3=0x12345678, done 3 cycles after accept.
REQ-040 clr asserted mid MEM_WAIT with mem_ack=1 same cycle -> no register write, mem_req=0, all registers 0, cmd_ready=1 next cycle.
REQ-041 LDI R0,0xFF with BUS_TRANSFER_ENGINE_R0_ZERO_EN -> dbg R0=0; without macro -> R0=0xFF.
REQ-042 NREG=32, WIDTH=16: LDI R31,0xFFFF, MOV R0,R31 -> R0=0xFFFF (macro undefined); cmd_valid held high in non-IDLE states produces no extra accept.

Source files
------------

// File: rtl/bus_transfer_engine.sv
// rtl/bus_transfer_engine.sv - single-bus register/memory transfer engine (MOV, LDI, LD, ST)
// Optional: define BUS_TRANSFER_ENGINE_R0_ZERO_EN to hard-wire R[0] to zero.
module bus_transfer_engine #(
  parameter int WIDTH = 32,
  parameter int NREG  = 16,
  parameter int IW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IW-1:0]    cmd_rd,
  input  logic [IW-1:0]    cmd_rs,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [WIDTH-1:0] bus,
  output logic             done,
  input  logic [IW-1:0]    dbg_sel,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b11;

`ifdef BUS_TRANSFER_ENGINE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_XFER, S_MEM_ADDR, S_MEM_DATA, S_MEM_WAIT, S_MEM_WB
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q;
  logic [IW-1:0]    rd_q, rs_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] mar_q, mdr_q;
  logic [WIDTH-1:0] regs_q [NREG];

  logic [WIDTH-1:0] bus_w, rs_val, rd_val;
  logic             rf_we, mar_we, mdr_bus_we, mdr_mem_we, done_w, mem_req_w;

  // R[0] reads as zero on every read path when the zero-register option is on.
  assign rs_val   = (R0_ZERO && rs_q == '0)    ? '0 : regs_q[rs_q];
  assign rd_val   = (R0_ZERO && rd_q == '0)    ? '0 : regs_q[rd_q];
  assign dbg_data = (R0_ZERO && dbg_sel == '0) ? '0 : regs_q[dbg_sel];

  assign cmd_ready = (state_q == S_IDLE);
  assign mem_req   = mem_req_w;
  assign mem_we    = mem_req_w && (op_q == OP_ST);
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign bus       = bus_w;
  assign done      = done_w && !clr;

  always_comb begin
    state_d    = state_q;
    bus_w      = '0;
    rf_we      = 1'b0;
    mar_we     = 1'b0;
    mdr_bus_we = 1'b0;
    mdr_mem_we = 1'b0;
    done_w     = 1'b0;
    mem_req_w  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = (cmd_op == OP_MOV || cmd_op == OP_LDI) ? S_XFER : S_MEM_ADDR;
        end
      end
      S_XFER: begin
        bus_w   = (op_q == OP_LDI) ? imm_q : rs_val;
        rf_we   = 1'b1;
        done_w  = 1'b1;
        state_d = S_IDLE;
      end
      S_MEM_ADDR: begin
        bus_w   = rs_val;
        mar_we  = 1'b1;
        state_d = (op_q == OP_ST) ? S_MEM_DATA : S_MEM_WAIT;
      end
      S_MEM_DATA: begin
        bus_w      = rd_val;
        mdr_bus_we = 1'b1;
        state_d    = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        mem_req_w = 1'b1;
        if (mem_ack) begin
          if (op_q == OP_ST) begin
            done_w  = 1'b1;
            state_d = S_IDLE;
          end else begin
            mdr_mem_we = 1'b1;
            state_d    = S_MEM_WB;
          end
        end
      end
      S_MEM_WB: begin
        bus_w   = mdr_q;
        rf_we   = 1'b1;
        done_w  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      op_q  <= '0;
      rd_q  <= '0;
      rs_q  <= '0;
      imm_q <= '0;
    end else if (cmd_valid && cmd_ready) begin
      op_q  <= cmd_op;
      rd_q  <= cmd_rd;
      rs_q  <= cmd_rs;
      imm_q <= cmd_imm;
    end
  end

  // Everything but a read-ack MDR load is fed from the shared bus.
  always_ff @(posedge clk) begin
    if (clr) begin
      mar_q <= '0;
      mdr_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (mar_we) begin
        mar_q <= bus_w;
      end
      if (mdr_bus_we) begin
        mdr_q <= bus_w;
      end else if (mdr_mem_we) begin
        mdr_q <= mem_rdata;
      end
      if (rf_we && !(R0_ZERO && rd_q == '0)) begin
        regs_q[rd_q] <= bus_w;
      end
    end
  end

endmodule

// File: tb/tb_bus_transfer_engine.sv
// tb/tb_bus_transfer_engine.sv - directed self-checking bench for bus_transfer_engine
module tb_bus_transfer_engine;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LDI = 2'b01;
  localparam logic [1:0] OP_LD  = 2'b10;
  localparam logic [1:0] OP_ST  = 2'b11;

`ifdef BUS_TRANSFER_ENGINE_R0_ZERO_EN
  localparam logic [31:0] EXP_R0_FF   = 32'h0;
  localparam logic [31:0] EXP_R0_FFFF = 32'h0;
`else
  localparam logic [31:0] EXP_R0_FF   = 32'hFF;
  localparam logic [31:0] EXP_R0_FFFF = 32'hFFFF;
`endif

  logic        clk, clr;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_rd, cmd_rs, dbg_sel;
  logic [31:0] cmd_imm, mem_addr, mem_wdata, mem_rdata, bus, dbg_data;
  logic        mem_req, mem_we, mem_ack, done;

  logic        d2_cmd_valid, d2_cmd_ready;
  logic [1:0]  d2_cmd_op;
  logic [4:0]  d2_cmd_rd, d2_cmd_rs, d2_dbg_sel;
  logic [15:0] d2_cmd_imm, d2_mem_addr, d2_mem_wdata, d2_mem_rdata, d2_bus, d2_dbg_data;
  logic        d2_mem_req, d2_mem_we, d2_mem_ack, d2_done;

  int checks   = 0;
  int failures = 0;

  bus_transfer_engine u_dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs(cmd_rs), .cmd_imm(cmd_imm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus(bus), .done(done),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  bus_transfer_engine #(.WIDTH(16), .NREG(32)) u_dut2 (
    .clk(clk), .clr(clr),
    .cmd_valid(d2_cmd_valid), .cmd_ready(d2_cmd_ready), .cmd_op(d2_cmd_op),
    .cmd_rd(d2_cmd_rd), .cmd_rs(d2_cmd_rs), .cmd_imm(d2_cmd_imm),
    .mem_req(d2_mem_req), .mem_we(d2_mem_we), .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata),
    .mem_rdata(d2_mem_rdata), .mem_ack(d2_mem_ack), .bus(d2_bus), .done(d2_done),
    .dbg_sel(d2_dbg_sel), .dbg_data(d2_dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Offer a command for one edge; returns in the cycle after acceptance.
  task automatic send(input logic [1:0] op, input logic [3:0] rd, input logic [3:0] rs,
                      input logic [31:0] imm);
    cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_imm = imm; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic dbg_check(input string tag, input logic [3:0] idx, input logic [31:0] exp);
    dbg_sel = idx;
    #1;
    check_eq(tag, dbg_data, exp);
  endtask

  task automatic do_ld(input string tag, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [31:0] exp_addr, input logic [31:0] rdata);
    send(OP_LD, rd, rs, 32'h0);
    check_eq({tag, "_addr_bus"}, bus, exp_addr);
    @(negedge clk);
    check_eq({tag, "_req"}, mem_req, 1'b1);
    check_eq({tag, "_we"}, mem_we, 1'b0);
    check_eq({tag, "_mem_addr"}, mem_addr, exp_addr);
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq({tag, "_done"}, done, 1'b1);
    check_eq({tag, "_wb_bus"}, bus, rdata);
    @(negedge clk);
    check_eq({tag, "_done_clear"}, done, 1'b0);
  endtask

  initial begin
    clr = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs = '0; cmd_imm = '0;
    mem_rdata = '0; mem_ack = 1'b0; dbg_sel = '0;
    d2_cmd_valid = 1'b0; d2_cmd_op = '0; d2_cmd_rd = '0; d2_cmd_rs = '0; d2_cmd_imm = '0;
    d2_mem_rdata = '0; d2_mem_ack = 1'b0; d2_dbg_sel = '0;
    repeat (2) @(negedge clk);
    clr = 1'b0;

    check_eq("rst_ready", cmd_ready, 1'b1);
    check_eq("rst_req", mem_req, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_bus", bus, 32'h0);
    dbg_check("rst_r5", 4'd5, 32'h0);

    // LDI R5,0xDEADBEEF ; MOV R7,R5
    send(OP_LDI, 4'd5, 4'd0, 32'hDEADBEEF);
    check_eq("ldi_done", done, 1'b1);
    check_eq("ldi_bus", bus, 32'hDEADBEEF);
    check_eq("ldi_busy", cmd_ready, 1'b0);
    @(negedge clk);
    check_eq("ldi_done_clear", done, 1'b0);
    send(OP_MOV, 4'd7, 4'd5, 32'h0);
    check_eq("mov_done", done, 1'b1);
    check_eq("mov_bus", bus, 32'hDEADBEEF);
    @(negedge clk);
    dbg_check("mov_r7", 4'd7, 32'hDEADBEEF);

    // ST [R1],R2 with four wait cycles before the ack
    send(OP_LDI, 4'd1, 4'd0, 32'h100);
    @(negedge clk);
    send(OP_LDI, 4'd2, 4'd0, 32'hCAFE);
    @(negedge clk);
    send(OP_ST, 4'd2, 4'd1, 32'h0);
    check_eq("st_addr_bus", bus, 32'h100);
    check_eq("st_addr_req", mem_req, 1'b0);
    @(negedge clk);
    check_eq("st_data_bus", bus, 32'hCAFE);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_eq("st_wait_req", mem_req, 1'b1);
      check_eq("st_wait_we", mem_we, 1'b1);
      check_eq("st_wait_addr", mem_addr, 32'h100);
      check_eq("st_wait_wdata", mem_wdata, 32'hCAFE);
      check_eq("st_wait_done", done, 1'b0);
      check_eq("st_wait_bus", bus, 32'h0);
      @(negedge clk);
    end
    mem_ack = 1'b1;
    #1;
    check_eq("st_ack_done", done, 1'b1);
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("st_after_req", mem_req, 1'b0);
    check_eq("st_after_ready", cmd_ready, 1'b1);
    check_eq("st_after_done", done, 1'b0);

    // LD R3,[R1] with immediate ack; then source==destination LD R2,[R2]
    do_ld("ld_r3", 4'd3, 4'd1, 32'h100, 32'h12345678);
    dbg_check("ld_r3_val", 4'd3, 32'h12345678);
    do_ld("ld_r2r2", 4'd2, 4'd2, 32'hCAFE, 32'h000055AA);
    dbg_check("ld_r2r2_val", 4'd2, 32'h000055AA);

    // Ack while idle has no effect
    mem_rdata = 32'hBAD0BAD0;
    mem_ack   = 1'b1;
    #1;
    check_eq("idle_ack_done", done, 1'b0);
    @(negedge clk);
    mem_ack = 1'b0;
    check_eq("idle_ack_ready", cmd_ready, 1'b1);
    dbg_check("idle_ack_r3", 4'd3, 32'h12345678);

    // clr coincident with ack in MEM_WAIT
    send(OP_LD, 4'd4, 4'd1, 32'h0);
    @(negedge clk);
    check_eq("clr_pre_req", mem_req, 1'b1);
    mem_rdata = 32'hAAAA5555;
    mem_ack   = 1'b1;
    clr       = 1'b1;
    #1;
    check_eq("clr_ack_done", done, 1'b0);
    @(negedge clk);
    clr = 1'b0; mem_ack = 1'b0;
    check_eq("clr_req", mem_req, 1'b0);
    check_eq("clr_ready", cmd_ready, 1'b1);
    check_eq("clr_mar", mem_addr, 32'h0);
    check_eq("clr_mdr", mem_wdata, 32'h0);
    dbg_check("clr_r4", 4'd4, 32'h0);
    dbg_check("clr_r5", 4'd5, 32'h0);
    dbg_check("clr_r7", 4'd7, 32'h0);
    dbg_check("clr_r1", 4'd1, 32'h0);

    // R0 behaviour depends on the zero-register option
    send(OP_LDI, 4'd0, 4'd0, 32'hFF);
    check_eq("r0_done", done, 1'b1);
    @(negedge clk);
    dbg_check("r0_val", 4'd0, EXP_R0_FF);

    // Wide-index / narrow-width instance; valid held into XFER with altered fields
    d2_cmd_op = OP_LDI; d2_cmd_rd = 5'd31; d2_cmd_rs = 5'd0; d2_cmd_imm = 16'hFFFF;
    d2_cmd_valid = 1'b1;
    @(negedge clk);
    check_eq("d2_ldi_done", d2_done, 1'b1);
    check_eq("d2_ldi_busy", d2_cmd_ready, 1'b0);
    d2_cmd_rd = 5'd30; d2_cmd_imm = 16'h1234;
    @(negedge clk);
    d2_cmd_valid = 1'b0;
    check_eq("d2_no_extra_done", d2_done, 1'b0);
    check_eq("d2_idle_ready", d2_cmd_ready, 1'b1);
    @(negedge clk);
    check_eq("d2_still_idle_done", d2_done, 1'b0);
    d2_dbg_sel = 5'd30;
    #1;
    check_eq("d2_r30", d2_dbg_data, 16'h0);
    d2_dbg_sel = 5'd31;
    #1;
    check_eq("d2_r31", d2_dbg_data, 16'hFFFF);
    @(negedge clk);
    d2_cmd_op = OP_MOV; d2_cmd_rd = 5'd0; d2_cmd_rs = 5'd31; d2_cmd_valid = 1'b1;
    @(negedge clk);
    d2_cmd_valid = 1'b0;
    check_eq("d2_mov_bus", d2_bus, 16'hFFFF);
    @(negedge clk);
    d2_dbg_sel = 5'd0;
    #1;
    check_eq("d2_r0", d2_dbg_data, EXP_R0_FFFF[15:0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
